// File: rtl/fpu_share_arbiter_if.sv
// fpu_share_arbiter_if
//   Bundles every signal of the FPU sharing arbiter other than clock/reset:
//   the requester-side request/response channels, the shared FPU wrapper
//   request/response channels, and the flush/busy/err sideband.
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the FPU port)
//     master - the environment's view (requesters plus FPU wrapper)
//   Requester i occupies [i*WIDTH +: WIDTH] of the packed operand buses,
//   [i*16 +: 16] of in_bits_ctrl and [i*LANES +: LANES] of the mask bus.
interface fpu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 512,
  parameter int LANES   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // requester side
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ-1:0]       in_ready;
  logic [NUM_REQ*WIDTH-1:0] in_bits_operands_0;
  logic [NUM_REQ*WIDTH-1:0] in_bits_operands_1;
  logic [NUM_REQ*WIDTH-1:0] in_bits_operands_2;
  logic [NUM_REQ*16-1:0]    in_bits_ctrl;
  logic [NUM_REQ*LANES-1:0] in_bits_simdMask;
  logic [NUM_REQ-1:0]       out_valid;
  logic [NUM_REQ-1:0]       out_ready;
  logic [WIDTH-1:0]         out_bits_result;
  logic [4:0]               out_bits_status;
  logic                     flush;
  logic                     busy;
  logic                     err;
  // FPU wrapper side
  logic                     fpu_req_valid;
  logic                     fpu_req_ready;
  logic [WIDTH-1:0]         fpu_req_bits_operands_0;
  logic [WIDTH-1:0]         fpu_req_bits_operands_1;
  logic [WIDTH-1:0]         fpu_req_bits_operands_2;
  logic [2:0]               fpu_req_bits_roundingMode;
  logic [4:0]               fpu_req_bits_op;
  logic [2:0]               fpu_req_bits_srcFormat;
  logic [2:0]               fpu_req_bits_dstFormat;
  logic [1:0]               fpu_req_bits_intFormat;
  logic [LANES-1:0]         fpu_req_bits_simdMask;
  logic [ID_W-1:0]          fpu_req_bits_tag;
  logic                     fpu_resp_valid;
  logic                     fpu_resp_ready;
  logic [WIDTH-1:0]         fpu_resp_bits_result;
  logic [4:0]               fpu_resp_bits_status;
  logic [ID_W-1:0]          fpu_resp_bits_tag;
  logic                     fpu_flush;
  logic                     fpu_busy;

  modport slave (
    input  in_valid, in_bits_operands_0, in_bits_operands_1, in_bits_operands_2,
           in_bits_ctrl, in_bits_simdMask, out_ready, flush,
           fpu_req_ready, fpu_resp_valid, fpu_resp_bits_result,
           fpu_resp_bits_status, fpu_resp_bits_tag, fpu_busy,
    output in_ready, out_valid, out_bits_result, out_bits_status, busy, err,
           fpu_req_valid, fpu_req_bits_operands_0, fpu_req_bits_operands_1,
           fpu_req_bits_operands_2, fpu_req_bits_roundingMode, fpu_req_bits_op,
           fpu_req_bits_srcFormat, fpu_req_bits_dstFormat, fpu_req_bits_intFormat,
           fpu_req_bits_simdMask, fpu_req_bits_tag, fpu_resp_ready, fpu_flush
  );

  modport master (
    output in_valid, in_bits_operands_0, in_bits_operands_1, in_bits_operands_2,
           in_bits_ctrl, in_bits_simdMask, out_ready, flush,
           fpu_req_ready, fpu_resp_valid, fpu_resp_bits_result,
           fpu_resp_bits_status, fpu_resp_bits_tag, fpu_busy,
    input  in_ready, out_valid, out_bits_result, out_bits_status, busy, err,
           fpu_req_valid, fpu_req_bits_operands_0, fpu_req_bits_operands_1,
           fpu_req_bits_operands_2, fpu_req_bits_roundingMode, fpu_req_bits_op,
           fpu_req_bits_srcFormat, fpu_req_bits_dstFormat, fpu_req_bits_intFormat,
           fpu_req_bits_simdMask, fpu_req_bits_tag, fpu_resp_ready, fpu_flush
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
//   Shares one FPU wrapper request/response port among NUM_REQ requesters.
//   Requests are arbitrated round-robin with zero-cycle issue latency; the
//   granted index is carried in the FPU tag and used to route the response
//   back. Per-requester credit counters cap in-flight ops at MAX_OUTSTANDING.
//   Ports:
//     clock - clock
//     reset - asynchronous active-high reset
//     bus   - fpu_share_arbiter_if.slave (requester channels, FPU channels,
//             flush/busy/err sideband)
module fpu_share_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 512,
  parameter int LANES           = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = $clog2(NUM_REQ)
) (
  input logic                clock,
  input logic                reset,
  fpu_share_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ID_W + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_lock_idx;
  logic [CNT_W-1:0] r_cnt [NUM_REQ];
  logic             r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_in_ready;
  logic [ID_W-1:0]    w_grant;
  logic               w_found;
  logic [SUM_W-1:0]   w_sum;
  logic               w_req_valid;
  logic               w_issue;
  logic [15:0]        w_ctrl;
  logic [NUM_REQ-1:0] w_out_valid;
  logic               w_rsp_ready;
  logic               w_rsp_hs;
  logic               w_tag_hit;
  logic               w_cnt_t_zero;
  logic               w_any_cnt;

  // Eligibility; reset gating keeps every request-side output low while reset is held
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = bus.in_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING))
                  && !bus.flush && !reset;
    end
  end

  // Grant: a stalled request keeps its grant while that requester stays
  // eligible; otherwise search upward from r_rr_ptr with wrap-around.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    if (r_state == ST_HOLD && w_elig[r_lock_idx]) begin
      w_grant = r_lock_idx;
      w_found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
        if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
        if (!w_found && w_elig[w_sum[ID_W-1:0]]) begin
          w_grant = w_sum[ID_W-1:0];
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_req_valid = |w_elig;
  assign w_issue     = w_req_valid && bus.fpu_req_ready;

  always_comb begin
    w_in_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_in_ready[i] = w_issue && (w_grant == ID_W'(i));
    end
  end

  // Lock FSM: hold the grant across a backpressured request
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_req_valid && !bus.fpu_req_ready) w_state_nxt = ST_HOLD;
  end

  assign w_ctrl = bus.in_bits_ctrl[int'(w_grant)*16 +: 16];

  assign bus.in_ready                  = w_in_ready;
  assign bus.fpu_req_valid             = w_req_valid;
  assign bus.fpu_req_bits_operands_0   = bus.in_bits_operands_0[int'(w_grant)*WIDTH +: WIDTH];
  assign bus.fpu_req_bits_operands_1   = bus.in_bits_operands_1[int'(w_grant)*WIDTH +: WIDTH];
  assign bus.fpu_req_bits_operands_2   = bus.in_bits_operands_2[int'(w_grant)*WIDTH +: WIDTH];
  assign bus.fpu_req_bits_simdMask     = bus.in_bits_simdMask[int'(w_grant)*LANES +: LANES];
  assign bus.fpu_req_bits_roundingMode = w_ctrl[15:13];
  assign bus.fpu_req_bits_op           = w_ctrl[12:8];
  assign bus.fpu_req_bits_srcFormat    = w_ctrl[7:5];
  assign bus.fpu_req_bits_dstFormat    = w_ctrl[4:2];
  assign bus.fpu_req_bits_intFormat    = w_ctrl[1:0];
  assign bus.fpu_req_bits_tag          = w_grant;

  // Response routing; a tag matching no requester is accepted and dropped
  always_comb begin
    w_out_valid  = '0;
    w_rsp_ready  = 1'b1;
    w_tag_hit    = 1'b0;
    w_cnt_t_zero = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.fpu_resp_bits_tag == ID_W'(i)) begin
        w_out_valid[i] = bus.fpu_resp_valid && !reset;
        w_rsp_ready    = bus.out_ready[i];
        w_tag_hit      = 1'b1;
        w_cnt_t_zero   = (r_cnt[i] == '0);
      end
    end
  end

  assign w_rsp_hs            = bus.fpu_resp_valid && w_rsp_ready;
  assign bus.out_valid       = w_out_valid;
  assign bus.fpu_resp_ready  = w_rsp_ready;
  assign bus.out_bits_result = bus.fpu_resp_bits_result;
  assign bus.out_bits_status = bus.fpu_resp_bits_status;
  assign bus.fpu_flush       = bus.flush && !reset;
  assign bus.err             = r_err;

  always_comb begin
    w_any_cnt = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_cnt[i] != '0) w_any_cnt = 1'b1;
    end
  end

  assign bus.busy = w_any_cnt || bus.fpu_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_HOLD) r_lock_idx <= w_grant;
      if (w_issue) begin
        r_rr_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
      end
      if (w_rsp_hs && (!w_tag_hit || w_cnt_t_zero)) r_err <= 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.flush) begin
          r_cnt[i] <= '0;
        end else if (w_in_ready[i] && !(w_rsp_hs && bus.fpu_resp_bits_tag == ID_W'(i))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_in_ready[i] && w_rsp_hs && bus.fpu_resp_bits_tag == ID_W'(i)
                     && r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one vector FPU request/response port (fpnew-based wrapper, 2-stage pipes) among NUM_REQ requesters, e.g. cores in a cluster.
- Issue side: round-robin arbitration. Response side: routes each result back using the requester index, which travels in the FPU tag.
- Per-requester credit counters bound outstanding ops so that one backpressured requester cannot occupy the whole FPU pipeline.
- Sits between the cluster's requesters and the FPU wrapper instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 512, operand/result width
- LANES, 16, SIMD mask width
- MAX_OUTSTANDING, 4, max in-flight ops per requester (1..15)
- ID_W, $clog2(NUM_REQ), FPU tag width

Ports:
- clock  in  1  clock
- reset  in  1  async active-high reset
- in_valid  in  NUM_REQ  per-requester request valid
- in_ready  out  NUM_REQ  per-requester request accept
- in_bits_operands_0/1/2  in  NUM_REQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
- in_bits_ctrl  in  NUM_REQ*16  per requester {rm[15:13], op[12:8], srcFmt[7:5], dstFmt[4:2], intFmt[1:0]}
- in_bits_simdMask  in  NUM_REQ*LANES  per-requester lane mask
- out_valid  out  NUM_REQ  per-requester response valid
- out_ready  in  NUM_REQ  per-requester response accept
- out_bits_result  out  WIDTH  shared response data, broadcast to all requesters
- out_bits_status  out  5  shared fflags
- flush  in  1  global flush
- busy  out  1  ops in flight
- err  out  1  sticky: response arrived for a requester with zero credits in use
- fpu_req_valid/fpu_req_ready  out/in  1  FPU issue handshake
- fpu_req_bits_operands_0/1/2  out  WIDTH  selected operands
- fpu_req_bits_roundingMode/op/srcFormat/dstFormat/intFormat  out  3/5/3/3/2  selected ctrl fields
- fpu_req_bits_simdMask  out  LANES  selected mask
- fpu_req_bits_tag  out  ID_W  granted requester index
- fpu_resp_valid/fpu_resp_ready  in/out  1  FPU response handshake
- fpu_resp_bits_result/status/tag  in  WIDTH/5/ID_W  FPU response
- fpu_flush  out  1  flush to FPU
- fpu_busy  in  1  FPU busy

Behaviour:
- Reset (async, active-high): rr_ptr=0, all cnt[i]=0, err=0. During reset, all in_ready, out_valid, fpu_req_valid and fpu_flush are 0.
- Eligibility: elig[i] = in_valid[i] && cnt[i] < MAX_OUTSTANDING && !flush.
- Grant: first eligible index found searching from rr_ptr upward, wrapping modulo NUM_REQ. The grant is combinational, with zero-cycle issue latency.
- fpu_req_valid = any elig. The fpu_req_bits_* fields are muxed from the granted requester, and tag = grant index.
- in_ready[i] = (grant==i) && fpu_req_valid && fpu_req_ready. All other in_ready bits are 0.
- On an issue handshake (fpu_req_valid && fpu_req_ready): rr_ptr <= (grant+1) mod NUM_REQ. When there is no handshake, rr_ptr holds.
- Valid stability: grant must not change while fpu_req_valid=1 && !fpu_req_ready, unless the granted requester drops in_valid. Implement this by locking the grant until the handshake completes.
- Response routing, with t = fpu_resp_bits_tag:
  - out_valid[t] = fpu_resp_valid; every other out_valid bit is 0.
  - fpu_resp_ready = out_ready[t].
  - out_bits_result and out_bits_status pass straight through from the FPU response.
- Credits:
  - cnt[i] increments on an issue handshake for i.
  - cnt[i] decrements on a response handshake with tag i.
  - Both in the same cycle for the same i: cnt[i] is unchanged.
  - Never exceeds MAX_OUTSTANDING: eligibility gating guarantees this.
- Underflow: a response handshake with cnt[t]==0 leaves cnt[t] at 0 and sets err=1. err stays set until reset.
- Out-of-range tag (t >= NUM_REQ when NUM_REQ is not a power of two): the response is dropped (fpu_resp_ready=1, no out_valid) and err=1.
- Flush:
  - fpu_flush = flush, combinational.
  - While flush=1, all in_ready=0 and fpu_req_valid=0.
  - In the cycle after any flush=1 cycle, all cnt are 0 and rr_ptr is unchanged. The FPU discards in-flight ops, so responses after a flush are not expected.
  - A response handshake in the flush cycle itself is still routed to the requester, but does not change cnt.
- busy = (any cnt != 0) || fpu_busy.
- Reset mid-operation clears all state immediately. Outstanding ops are forgotten, and the FPU is reset by the same reset.

Test Plan:
- All 4 requesters hold valid with fpu_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; tags match; each in_ready pulses once per 4 cycles.
- Requester 2 alone issues 4 ops, responses withheld (fpu_resp_valid=0) -> cnt[2]=4, in_ready[2]=0 on 5th cycle, requester 1 still granted same cycle.
- fpu_resp_valid with tag=1, out_ready[1]=0 for 3 cycles -> fpu_resp_ready=0 for 3 cycles, out_valid[1]=1 only, result held; handshake on cycle 4, cnt[1] decrements by 1.
- Issue and response handshake for requester 0 in same cycle with cnt[0]=2 -> cnt[0] stays 2.
- 3 ops in flight (cnt=1,1,1,0), pulse flush for 1 cycle -> fpu_flush=1, no in_ready that cycle, all cnt=0 next cycle, busy follows fpu_busy.
- Inject response tag=3 with cnt[3]=0 -> err=1 and stays 1; assert reset asynchronously mid-stream -> err=0, cnt=0, outputs 0 without a clock edge.
